// File: rtl/mc_bus_responder.sv
// Responder for the MCU asynchronous parallel bus: synchronizes and qualifies the
// active-low strobes, then issues one-cycle register write/read strobes.
module mc_bus_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 2,
  parameter int USE_CE      = 0,
  parameter int ADD_WIDTH   = 6,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mc_ce,
  input  logic                  mc_we,
  input  logic                  mc_oe,
  input  logic [ADD_WIDTH-1:0]  mc_add,
  input  logic [DATA_WIDTH-1:0] mc_data_in,
  output logic [DATA_WIDTH-1:0] mc_data_out,
  output logic                  mc_data_oe,
  output logic                  wr_strobe,
  output logic [ADD_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_strobe,
  output logic [ADD_WIDTH-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  proto_err,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE, WRITE, WR_HOLD, READ, RD_FETCH, RD_DRIVE, ERR
  } state_t;

  localparam logic [2:0] QUAL_CNT = 3'(MIN_LOW - 1);
  localparam logic [2:0] SAT_CNT  = 3'(MIN_LOW);

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  ceSync_q, weSync_q, oeSync_q;
  logic [SYNC_STAGES-1:0]  fill_q;
  logic                    weArm_q, oeArm_q;
  logic [2:0]              weCnt_q, weCnt_d, oeCnt_q, oeCnt_d;
  logic [ADD_WIDTH-1:0]    add_q, wrAddr_q, rdAddr_q;
  logic [DATA_WIDTH-1:0]   dataIn_q, wrData_q, dataOut_q;
  logic                    dataOe_q, protoErr_q;

  logic ceS, weS, oeS, syncValid, sel;
  logic weLow, oeLow, weQual, oeQual, setErr;

  assign ceS       = ceSync_q[SYNC_STAGES-1];
  assign weS       = weSync_q[SYNC_STAGES-1];
  assign oeS       = oeSync_q[SYNC_STAGES-1];
  assign syncValid = fill_q[SYNC_STAGES-1];
  assign sel       = (USE_CE != 0) ? ~ceS : 1'b1;

  // A strobe may only count once it has been seen high after reset, and the
  // preset chain contents do not count as a real high sample.
  assign weLow  = ~weS & sel & weArm_q;
  assign oeLow  = ~oeS & sel & oeArm_q;
  assign weQual = weLow && (weCnt_q >= QUAL_CNT);
  assign oeQual = oeLow && (oeCnt_q >= QUAL_CNT);

  always_comb begin
    weCnt_d = '0;
    oeCnt_d = '0;
    if (state_q == IDLE && weLow) weCnt_d = (weCnt_q == SAT_CNT) ? weCnt_q : weCnt_q + 3'd1;
    if (state_q == IDLE && oeLow) oeCnt_d = (oeCnt_q == SAT_CNT) ? oeCnt_q : oeCnt_q + 3'd1;
  end

  always_comb begin
    state_d = state_q;
    setErr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (weQual || oeQual) begin
          if (~weS && ~oeS) begin
            state_d = ERR;
            setErr  = 1'b1;
          end else if (weQual) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE:    state_d = WR_HOLD;
      WR_HOLD:  if (weS) state_d = IDLE;
      READ:     state_d = RD_FETCH;
      RD_FETCH: state_d = RD_DRIVE;
      RD_DRIVE: if (oeS) state_d = IDLE;
      ERR:      if (weS && oeS) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ceSync_q   <= '1;
      weSync_q   <= '1;
      oeSync_q   <= '1;
      fill_q     <= '0;
      weArm_q    <= 1'b0;
      oeArm_q    <= 1'b0;
      weCnt_q    <= '0;
      oeCnt_q    <= '0;
      add_q      <= '0;
      dataIn_q   <= '0;
      state_q    <= IDLE;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      rdAddr_q   <= '0;
      dataOut_q  <= '0;
      dataOe_q   <= 1'b0;
      protoErr_q <= 1'b0;
    end else begin
      ceSync_q   <= {ceSync_q[SYNC_STAGES-2:0], mc_ce};
      weSync_q   <= {weSync_q[SYNC_STAGES-2:0], mc_we};
      oeSync_q   <= {oeSync_q[SYNC_STAGES-2:0], mc_oe};
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      weArm_q    <= weArm_q | (syncValid & weS);
      oeArm_q    <= oeArm_q | (syncValid & oeS);
      weCnt_q    <= weCnt_d;
      oeCnt_q    <= oeCnt_d;
      add_q      <= mc_add;
      dataIn_q   <= mc_data_in;
      state_q    <= state_d;
      protoErr_q <= protoErr_q | setErr;
      if (state_q == IDLE && state_d == WRITE) begin
        wrAddr_q <= add_q;
        wrData_q <= dataIn_q;
      end
      if (state_q == IDLE && state_d == READ) rdAddr_q <= add_q;
      // rd_data is valid in the cycle after rd_strobe, i.e. while in RD_FETCH.
      if (state_q == RD_FETCH) begin
        dataOut_q <= rd_data;
        dataOe_q  <= 1'b1;
      end
      if (state_q == RD_DRIVE && oeS) dataOe_q <= 1'b0;
    end
  end

  assign wr_strobe   = (state_q == WRITE);
  assign rd_strobe   = (state_q == READ);
  assign busy        = (state_q != IDLE);
  assign wr_addr     = wrAddr_q;
  assign wr_data     = wrData_q;
  assign rd_addr     = rdAddr_q;
  assign mc_data_out = dataOut_q;
  assign mc_data_oe  = dataOe_q;
  assign proto_err   = protoErr_q;

endmodule
